// File: rtl/uart_xcvr.sv
// rtl/uart_xcvr.sv - parametrised full-duplex UART transceiver with voted RX sampling
// Defining UART_PARITY_EN adds a parity bit to both directions (PARITY_ODD selects odd parity).
module uart_xcvr #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1
`ifdef UART_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 RX,
    output logic                 TX,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy
);
    localparam int DIV      = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int BIT_CLKS = DIV * OVERSAMPLE;
    localparam int DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW       = $clog2(OVERSAMPLE);
    localparam int BW       = $clog2(BIT_CLKS);
    localparam int NW       = $clog2(DATA_BITS + STOP_BITS + 1);

    localparam logic [SW-1:0] S_VA  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_VB  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_VC  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd4;
`ifdef UART_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
    localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

    generate
        if (DIV < 1 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_param_check
            $error("uart_xcvr: need CLK_HZ/(BAUD*OVERSAMPLE) >= 1 and even OVERSAMPLE >= 8");
        end
    endgenerate

    // ---------------- receiver ----------------
    logic                 rx_s1, rx_s2, rx_prev;
    logic [2:0]           rx_state;
    logic [DW-1:0]        rx_div;
    logic [SW-1:0]        rx_samp;
    logic [NW-1:0]        rx_bit;
    logic [1:0]           rx_votes;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_tick, rx_vote_now, rx_bit_end, rx_bit_val;

    assign rx_tick     = (rx_div == DW'(DIV - 1));
    assign rx_vote_now = rx_tick && (rx_samp == S_VC);
    assign rx_bit_end  = rx_tick && (rx_samp == S_END);
    // third vote is the live synchronised sample taken on the rx_vote_now cycle
    assign rx_bit_val  = (rx_votes[0] & rx_votes[1]) | (rx_votes[0] & rx_s2) | (rx_votes[1] & rx_s2);

    always_ff @(posedge CLK) begin
        if (rst) begin
            rx_s1        <= 1'b1;
            rx_s2        <= 1'b1;
            rx_prev      <= 1'b1;
            rx_state     <= ST_IDLE;
            rx_div       <= '0;
            rx_samp      <= '0;
            rx_bit       <= '0;
            rx_votes     <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_s1        <= RX;
            rx_s2        <= rx_s1;
            rx_prev      <= rx_s2;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            if (rx_state == ST_IDLE) begin
                rx_div  <= '0;
                rx_samp <= '0;
                rx_bit  <= '0;
                if (rx_prev && !rx_s2) rx_state <= ST_START;
            end else begin
                rx_div <= rx_tick ? '0 : rx_div + DW'(1);
                if (rx_tick) rx_samp <= rx_bit_end ? '0 : rx_samp + SW'(1);
                if (rx_tick && rx_samp == S_VA) rx_votes[0] <= rx_s2;
                if (rx_tick && rx_samp == S_VB) rx_votes[1] <= rx_s2;
                case (rx_state)
                    ST_START: begin
                        if (rx_tick && rx_samp == S_VB && rx_s2) rx_state <= ST_IDLE;
                        else if (rx_bit_end)                     rx_state <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (rx_vote_now) rx_shift <= {rx_bit_val, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit_end) begin
                            if (rx_bit == NW'(DATA_BITS - 1)) begin
                                rx_bit   <= '0;
                                rx_state <= ST_AFTER_DATA;
                            end else begin
                                rx_bit <= rx_bit + NW'(1);
                            end
                        end
                    end
`ifdef UART_PARITY_EN
                    ST_PARITY: begin
                        if (rx_bit_end) rx_state <= ST_STOP;
                    end
`endif
                    ST_STOP: begin
                        // leave at mid stop bit so a following start edge is not missed
                        if (rx_vote_now) begin
                            rx_state <= ST_IDLE;
                            if (rx_bit_val) begin
                                rx_data  <= rx_shift;
                                rx_valid <= 1'b1;
                            end else begin
                                rx_frame_err <= 1'b1;
                            end
                        end
                    end
                    default: rx_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef UART_PARITY_EN
    logic rx_par_bad;

    always_ff @(posedge CLK) begin
        if (rst) begin
            rx_par_bad    <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            rx_parity_err <= 1'b0;
            if (rx_state == ST_PARITY && rx_vote_now)
                rx_par_bad <= rx_bit_val ^ (^rx_shift) ^ PARITY_ODD;
            if (rx_state == ST_STOP && rx_vote_now)
                rx_parity_err <= rx_par_bad;
        end
    end
`else
    assign rx_parity_err = 1'b0;
`endif

    // ---------------- transmitter ----------------
    logic [2:0]           tx_state;
    logic [BW-1:0]        tx_cnt;
    logic [NW-1:0]        tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_bit_end;
`ifdef UART_PARITY_EN
    logic                 tx_par;
`endif

    assign tx_bit_end = (tx_cnt == BW'(BIT_CLKS - 1));
    assign tx_busy    = ~tx_ready;

    always_ff @(posedge CLK) begin
        if (rst) begin
            TX       <= 1'b1;
            tx_ready <= 1'b1;
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else if (tx_state == ST_IDLE) begin
            tx_cnt <= '0;
            tx_bit <= '0;
            if (tx_valid) begin
                tx_shift <= tx_data;
`ifdef UART_PARITY_EN
                tx_par   <= (^tx_data) ^ PARITY_ODD;
`endif
                tx_state <= ST_START;
                tx_ready <= 1'b0;
                TX       <= 1'b0;
            end
        end else begin
            tx_cnt <= tx_bit_end ? '0 : tx_cnt + BW'(1);
            if (tx_bit_end) begin
                case (tx_state)
                    ST_START: begin
                        TX       <= tx_shift[0];
                        tx_state <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (tx_bit == NW'(DATA_BITS - 1)) begin
                            tx_bit   <= '0;
                            tx_state <= ST_AFTER_DATA;
`ifdef UART_PARITY_EN
                            TX       <= tx_par;
`else
                            TX       <= 1'b1;
`endif
                        end else begin
                            tx_bit   <= tx_bit + NW'(1);
                            TX       <= tx_shift[1];
                            tx_shift <= tx_shift >> 1;
                        end
                    end
`ifdef UART_PARITY_EN
                    ST_PARITY: begin
                        TX       <= 1'b1;
                        tx_state <= ST_STOP;
                    end
`endif
                    ST_STOP: begin
                        if (tx_bit == NW'(STOP_BITS - 1)) begin
                            tx_bit   <= '0;
                            tx_state <= ST_IDLE;
                            tx_ready <= 1'b1;
                        end else begin
                            tx_bit <= tx_bit + NW'(1);
                        end
                    end
                    default: begin
                        TX       <= 1'b1;
                        tx_ready <= 1'b1;
                        tx_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_xcvr.sv
// tb/tb_uart_xcvr.sv - self-checking bench for uart_xcvr (RX table, TX waveform, loopback, reset)
`timescale 1ns/1ps
module tb_uart_xcvr;
    localparam int CLK_HZ    = 100000000;
    localparam int BAUD      = 1000000;
    localparam int OS        = 16;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    localparam int BIT_CLKS  = (CLK_HZ / (BAUD * OS)) * OS;
    localparam int RX_BIT_NS = 970;
`ifdef UART_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NBITS = 1 + DATA_BITS + P + STOP_BITS;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic       rx_drv = 1'b1;
    logic       loop = 1'b0;
    logic       RX, TX;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err, rx_parity_err;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_busy;

    int         checks = 0;
    int         errors = 0;
    int         pulse_cnt = 0;
    logic [7:0] last_good = 8'h00;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       par_flip;
        int         gap;
    } vec_t;
    vec_t vecs[8];

    always #5 CLK = ~CLK;
    assign RX = loop ? TX : rx_drv;

    uart_xcvr #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS)
`ifdef UART_PARITY_EN
        , .PARITY_ODD(1'b0)
`endif
    ) dut (
        .CLK(CLK), .rst(rst), .RX(RX), .TX(TX),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (!rst && (rx_valid || rx_frame_err || rx_parity_err)) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                check("rx_unexpected_pulse", {29'd0, rx_valid, rx_frame_err, rx_parity_err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rx_valid", rx_valid, !e.ferr);
                check("rx_frame_err", rx_frame_err, e.ferr);
                check("rx_parity_err", rx_parity_err, e.perr);
                check("rx_data", rx_data, e.data);
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip);
        rx_drv = 1'b0;
        #(RX_BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            #(RX_BIT_NS);
        end
`ifdef UART_PARITY_EN
        rx_drv = (^d) ^ flip;
        #(RX_BIT_NS);
`endif
        rx_drv = stop;
        #(RX_BIT_NS);
        rx_drv = 1'b1;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic ferr, input logic flip);
        exp_t e;
        e.data = ferr ? last_good : d;
        e.ferr = ferr;
`ifdef UART_PARITY_EN
        e.perr = flip;
`else
        e.perr = 1'b0;
`endif
        if (!ferr) last_good = d;
        exp_q.push_back(e);
    endtask

    task automatic start_tx(input logic [7:0] d);
        @(negedge CLK);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge CLK);
        #1;
        tx_valid = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   pc;
        int   waited;
        logic exp_bits[16];

        vecs[0] = '{8'h55, 1'b1, 1'b0, 2};
        vecs[1] = '{8'hA3, 1'b1, 1'b0, 0};
        vecs[2] = '{8'hA3, 1'b1, 1'b0, 2};
        vecs[3] = '{8'hA3, 1'b0, 1'b0, 2};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 2};
        vecs[5] = '{8'hFF, 1'b1, 1'b0, 0};
        vecs[6] = '{8'h3C, 1'b1, 1'b1, 2};
        vecs[7] = '{8'h81, 1'b0, 1'b1, 3};

        repeat (8) @(posedge CLK);
        #1;
        check("reset_TX", TX, 1);
        check("reset_tx_ready", tx_ready, 1);
        check("reset_tx_busy", tx_busy, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_pulses", {rx_valid, rx_frame_err, rx_parity_err}, 0);
        @(negedge CLK);
        rst = 1'b0;
        #(10 * RX_BIT_NS);

        for (int i = 0; i < 8; i++) begin
            pc = pulse_cnt;
            push_exp(vecs[i].data, !vecs[i].stop, vecs[i].par_flip);
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].par_flip);
            #(vecs[i].gap * RX_BIT_NS);
            check("rx_pulse_per_frame", pulse_cnt, pc + 1);
        end

        // short low glitch must be rejected, then a normal frame must still be received
        pc = pulse_cnt;
        rx_drv = 1'b0;
        #200;
        rx_drv = 1'b1;
        #(3 * RX_BIT_NS);
        check("glitch_no_pulse", pulse_cnt, pc);
        push_exp(8'h96, 1'b0, 1'b0);
        send_frame(8'h96, 1'b1, 1'b0);
        #(2 * RX_BIT_NS);
        check("after_glitch_pulse", pulse_cnt, pc + 1);

        // TX waveform for 0xA3, with an ignored request while busy
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[1 + i] = tx_data_bit(8'hA3, i);
`ifdef UART_PARITY_EN
        exp_bits[9] = ^8'hA3;
`endif
        for (int i = 1 + DATA_BITS + P; i < NBITS; i++) exp_bits[i] = 1'b1;
        start_tx(8'hA3);
        check("tx_fall_after_accept", TX, 0);
        check("tx_ready_after_accept", tx_ready, 0);
        check("tx_busy_after_accept", tx_busy, 1);
        for (int c = 1; c <= NBITS * BIT_CLKS; c++) begin
            @(posedge CLK);
            #1;
            if (c % BIT_CLKS == BIT_CLKS / 2) check("tx_bit", TX, exp_bits[c / BIT_CLKS]);
            if (c == 200) begin
                tx_data  = 8'h00;
                tx_valid = 1'b1;
            end
            if (c == 201) tx_valid = 1'b0;
            if (c == NBITS * BIT_CLKS - 1) check("tx_ready_low_last_cycle", tx_ready, 0);
        end
        check("tx_ready_rise", tx_ready, 1);
        check("tx_idle_line", TX, 1);
        repeat (5) @(posedge CLK);
        #1;
        check("tx_busy_request_ignored", tx_ready, 1);

        // loopback
        loop = 1'b1;
        foreach (exp_bits[i]) exp_bits[i] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] lb [3];
            lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h5A;
            pc = pulse_cnt;
            push_exp(lb[i], 1'b0, 1'b0);
            start_tx(lb[i]);
            waited = 0;
            while (!tx_ready && waited < 20 * BIT_CLKS) begin
                @(posedge CLK);
                #1;
                waited++;
            end
            check("loop_tx_done", tx_ready, 1);
            repeat (4) @(posedge CLK);
            #1;
            check("loop_rx_pulse", pulse_cnt, pc + 1);
        end

        // reset in the middle of a looped-back frame
        start_tx(8'h5A);
        repeat (3 * BIT_CLKS) @(posedge CLK);
        @(negedge CLK);
        rst = 1'b1;
        @(posedge CLK);
        #1;
        check("midreset_TX", TX, 1);
        check("midreset_tx_ready", tx_ready, 1);
        check("midreset_tx_busy", tx_busy, 0);
        check("midreset_rx_data", rx_data, 0);
        @(negedge CLK);
        rst = 1'b0;
        pc = pulse_cnt;
        repeat (12 * BIT_CLKS) @(posedge CLK);
        #1;
        check("midreset_no_rx_pulse", pulse_cnt, pc);
        check("midreset_tx_stays_idle", tx_ready, 1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic tx_data_bit(input logic [7:0] d, input int i);
        return d[i];
    endfunction
endmodule
